// File: rtl/pu_riscv_ahb3_mmio_master_if.sv
// Command/response and AHB3-Lite bus signals of the MMIO master, grouped for the master and its peer.
// cmd_req/cmd_ack is a valid/ready pair: a command transfers on the HCLK edge where both are high, and cmd_* must hold until then; rsp_valid is a pulse with no backpressure.
interface pu_riscv_ahb3_mmio_master_if #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
);
   logic                  cmd_req;
   logic                  cmd_we;
   logic [HADDR_SIZE-1:0] cmd_addr;
   logic [2:0]            cmd_size;
   logic [HDATA_SIZE-1:0] cmd_wdata;
   logic                  cmd_ack;
   logic                  rsp_valid;
   logic [HDATA_SIZE-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;
   logic                  HSEL;
   logic [1:0]            HTRANS;
   logic [HADDR_SIZE-1:0] HADDR;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [HDATA_SIZE-1:0] HWDATA;
   logic [HDATA_SIZE-1:0] HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      input  cmd_req, cmd_we, cmd_addr, cmd_size, cmd_wdata,
      output cmd_ack, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      output cmd_req, cmd_we, cmd_addr, cmd_size, cmd_wdata,
      input  cmd_ack, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/pu_riscv_ahb3_mmio_master.sv
// AHB3-Lite single-transfer master: turns cmd/rsp requests into pipelined NONSEQ SINGLE transfers
// with wait-state, two-cycle ERROR and watchdog-timeout handling.
module pu_riscv_ahb3_mmio_master #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int TIMEOUT    = 1024
) (
   input logic                       HCLK,
   input logic                       HRESETn,
   pu_riscv_ahb3_mmio_master_if.master bus
);
   localparam int         CW            = $clog2(TIMEOUT + 1);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // A slot: the transfer currently in its address phase (these regs drive HADDR/HWRITE/HSIZE)
   logic                  a_full_q, a_we_q;
   logic [HADDR_SIZE-1:0] a_addr_q;
   logic [2:0]            a_size_q;
   logic [HDATA_SIZE-1:0] a_wdata_q;
   // D slot: the transfer currently in its data phase
   logic                  d_full_q, d_we_q;
   logic [HDATA_SIZE-1:0] hwdata_q;
   logic [CW-1:0]         cnt_q;
   logic                  cxl_pend_q, cxl_fire_q;
   logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
   logic [HDATA_SIZE-1:0] rsp_rdata_q;

   logic [HADDR_SIZE-1:0] size_mask;
   logic                  aligned, err_first, tmo_hit, d_done, ack_al, ack_mis;

   always_comb begin
      size_mask = (HADDR_SIZE'(1) << bus.cmd_size) - HADDR_SIZE'(1);
      aligned   = (bus.cmd_addr & size_mask) == '0;
      err_first = d_full_q & ~bus.HREADY & bus.HRESP;
      tmo_hit   = d_full_q & ~bus.HREADY & (cnt_q == CW'(TIMEOUT - 1));
      d_done    = d_full_q & bus.HREADY;
      ack_al    = bus.cmd_req & aligned & (~a_full_q | bus.HREADY) & ~err_first & ~tmo_hit;
      // a misaligned command only needs a response slot, which must not collide with bus responses
      ack_mis   = bus.cmd_req & ~aligned & ~a_full_q & ~d_full_q & ~cxl_pend_q & ~cxl_fire_q;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_full_q   <= 1'b0;
         a_we_q     <= 1'b0;
         a_addr_q   <= '0;
         a_size_q   <= '0;
         a_wdata_q  <= '0;
         d_full_q   <= 1'b0;
         d_we_q     <= 1'b0;
         hwdata_q   <= '0;
         cnt_q      <= '0;
         cxl_pend_q <= 1'b0;
         cxl_fire_q <= 1'b0;
      end else begin
         if (tmo_hit) begin
            a_full_q   <= 1'b0;
            d_full_q   <= 1'b0;
            cxl_pend_q <= 1'b0;
         end else if (err_first) begin
            // the address-phase transfer is withdrawn and answered after the failing one
            a_full_q   <= 1'b0;
            cxl_pend_q <= a_full_q;
         end else begin
            if (bus.HREADY) begin
               d_full_q <= a_full_q;
               if (a_full_q) begin
                  d_we_q <= a_we_q;
                  if (a_we_q) hwdata_q <= a_wdata_q;
               end
               if (d_done) cxl_pend_q <= 1'b0;
            end
            if (ack_al) begin
               a_full_q  <= 1'b1;
               a_we_q    <= bus.cmd_we;
               a_addr_q  <= bus.cmd_addr;
               a_size_q  <= bus.cmd_size;
               a_wdata_q <= bus.cmd_wdata;
            end else if (bus.HREADY) begin
               a_full_q <= 1'b0;
            end
         end
         cxl_fire_q <= d_done & cxl_pend_q;
         if (d_full_q && !bus.HREADY && !tmo_hit) cnt_q <= cnt_q + CW'(1);
         else                                     cnt_q <= '0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         if (d_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.HRESP;
            if (!d_we_q && !bus.HRESP) rsp_rdata_q <= bus.HRDATA;
         end else if (tmo_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
         end else if (cxl_fire_q || ack_mis) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
         end
      end
   end

   assign bus.cmd_ack     = ack_al | ack_mis;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.HSEL        = a_full_q;
   assign bus.HTRANS      = a_full_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.HADDR       = a_addr_q;
   assign bus.HWRITE      = a_we_q;
   assign bus.HSIZE       = a_size_q;
   assign bus.HBURST      = 3'b000;
   assign bus.HPROT       = 4'b0011;
   assign bus.HWDATA      = hwdata_q;
endmodule
